// File: rtl/audio_pkg.sv
// Constants shared by the I2S transmit serializer and the future I2S receiver.
package audio_pkg;

   localparam int Q15_WIDTH        = 16;
   localparam int I2S_FRAME_BITS   = 2 * Q15_WIDTH;
   localparam int DEFAULT_BCLK_DIV = 8;

   // Word-select level for a frame bit position: low for the left slot, raised one bit early.
   function automatic logic i2s_ws_level(input int unsigned bit_pos, input int unsigned slot_bits);
      return !((bit_pos == 2 * slot_bits - 1) || (bit_pos + 2 <= slot_bits));
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a pop and a push may share a cycle even when full.
module sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (level == LW'(DEPTH));
   assign empty    = (level == '0);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   // NOTE: the storage array has no reset; pointers and level alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // NOTE: state registers use non-blocking assignments so every update reads pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/i2s_tx_serializer.sv
// Philips I2S master transmitter: buffers mono samples and sends each in both the left and right slots.
module i2s_tx_serializer
   import audio_pkg::*;
#(
   parameter int DATA_WIDTH = Q15_WIDTH,
   parameter int BCLK_DIV   = DEFAULT_BCLK_DIV,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATA_WIDTH-1:0]         audio_in,
   input  logic                          audio_valid,
   input  logic                          clear_flags,
   output logic                          i2s_bclk,
   output logic                          i2s_lrclk,
   output logic                          i2s_sdata,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   output logic                          underrun
);

   localparam int FRAME_BITS = 2 * DATA_WIDTH;
   localparam int DIV_W      = $clog2(BCLK_DIV);
   localparam int BIT_W      = $clog2(FRAME_BITS);
   localparam logic [DATA_WIDTH-1:0] MSB_ONLY = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic [DIV_W-1:0]      div_cnt;
   logic [BIT_W-1:0]      bit_cnt;
   logic [BIT_W-1:0]      bit_next;
   logic [BIT_W-1:0]      slot_bit;
   logic [DATA_WIDTH-1:0] frame_reg;
   logic [DATA_WIDTH-1:0] frame_next;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  div_wrap;
   logic                  fall_evt;
   logic                  frame_start;
   logic                  pop_ok;
   logic                  ovf_set;
   logic                  udr_set;
   logic                  sdata_next;
   logic                  lrclk_next;

   sync_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (audio_valid),
      .push_data (audio_in),
      .pop       (frame_start),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   assign div_wrap    = (div_cnt == DIV_W'(BCLK_DIV - 1));
   assign fall_evt    = div_wrap && i2s_bclk;
   assign bit_next    = (bit_cnt == BIT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt + 1'b1;
   assign frame_start = fall_evt && (bit_next == '0);
   assign pop_ok      = frame_start && !fifo_empty;
   // A full FIFO only accepts a new sample when the frame start frees a slot in the same cycle.
   assign ovf_set     = audio_valid && fifo_full && !pop_ok;
   assign udr_set     = frame_start && fifo_empty;

   always_comb begin
      // NOTE: every signal written here gets a default first so no latch is inferred.
      slot_bit   = bit_next;
      frame_next = frame_reg;
      if (bit_next >= BIT_W'(DATA_WIDTH)) begin
         slot_bit = bit_next - BIT_W'(DATA_WIDTH);
      end
      if (frame_start) begin
         frame_next = fifo_empty ? '0 : fifo_data;
      end
      sdata_next = |(frame_next & (MSB_ONLY >> slot_bit));
      lrclk_next = i2s_ws_level(32'(bit_next), DATA_WIDTH);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt   <= '0;
         bit_cnt   <= BIT_W'(FRAME_BITS - 1);
         frame_reg <= '0;
         i2s_bclk  <= 1'b0;
         i2s_lrclk <= 1'b0;
         i2s_sdata <= 1'b0;
         overflow  <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
         if (div_wrap) begin
            i2s_bclk <= ~i2s_bclk;
         end
         // Data and word select move only with BCLK falling so the DAC samples them on the rise.
         if (fall_evt) begin
            bit_cnt   <= bit_next;
            frame_reg <= frame_next;
            i2s_sdata <= sdata_next;
            i2s_lrclk <= lrclk_next;
         end
         overflow <= ovf_set | (overflow & ~clear_flags);
         underrun <= udr_set | (underrun & ~clear_flags);
      end
   end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: cycle-accurate scoreboard of the I2S stream plus per-scenario checks.
module tb_i2s_tx_serializer;

   localparam int DW     = 16;
   localparam int BD     = 2;
   localparam int DEPTH  = 4;
   localparam int FB     = 2 * DW;
   localparam int BCLK_T = 2 * BD;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] audio_in = '0;
   logic          audio_valid = 1'b0;
   logic          clear_flags = 1'b0;
   logic          i2s_bclk;
   logic          i2s_lrclk;
   logic          i2s_sdata;
   logic [2:0]    fifo_level;
   logic          overflow;
   logic          underrun;

   int checks = 0;
   int errors = 0;

   i2s_tx_serializer #(
      .DATA_WIDTH (DW),
      .BCLK_DIV   (BD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .audio_in    (audio_in),
      .audio_valid (audio_valid),
      .clear_flags (clear_flags),
      .i2s_bclk    (i2s_bclk),
      .i2s_lrclk   (i2s_lrclk),
      .i2s_sdata   (i2s_sdata),
      .fifo_level  (fifo_level),
      .overflow    (overflow),
      .underrun    (underrun)
   );

   always #5 clk = ~clk;

   // Reference model state: cycle count since reset release and a queue of accepted samples.
   int            cyc = 0;
   bit            started = 1'b0;
   logic [DW-1:0] model_q[$];
   logic [DW-1:0] cur_frame = '0;
   logic [DW-1:0] shifted;
   logic          exp_bclk = 1'b0;
   logic          exp_lr = 1'b0;
   logic          exp_sd = 1'b0;
   logic          exp_ovf = 1'b0;
   logic          exp_udr = 1'b0;
   logic [FB-1:0] cap_sd = '0;
   logic [FB-1:0] cap_lr = '0;
   logic [FB-1:0] frame_log[$];
   logic [FB-1:0] lr_log[$];
   logic          s_rst, s_valid, s_clear, fall, fstart, pop_ok, ovf_set;
   logic [DW-1:0] s_data;
   int            pre_size;
   int            kbit;

   always @(posedge clk) begin
      s_rst   = rst;
      s_valid = audio_valid;
      s_clear = clear_flags;
      s_data  = audio_in;
      fall    = 1'b0;
      kbit    = 0;
      if (s_rst) begin
         started   = 1'b1;
         cyc       = 0;
         model_q.delete();
         frame_log.delete();
         lr_log.delete();
         cur_frame = '0;
         cap_sd    = '0;
         cap_lr    = '0;
         exp_bclk  = 1'b0;
         exp_lr    = 1'b0;
         exp_sd    = 1'b0;
         exp_ovf   = 1'b0;
         exp_udr   = 1'b0;
      end else if (started) begin
         cyc++;
         pre_size = model_q.size();
         fall     = (cyc >= BCLK_T) && (cyc % BCLK_T == 0);
         kbit     = fall ? ((cyc - BCLK_T) / BCLK_T) % FB : 0;
         fstart   = fall && (kbit == 0);
         pop_ok   = fstart && (pre_size > 0);
         ovf_set  = 1'b0;
         if (fstart) begin
            if (pop_ok) cur_frame = model_q.pop_front();
            else        cur_frame = '0;
         end
         if (s_valid) begin
            if (pre_size < DEPTH || pop_ok) model_q.push_back(s_data);
            else                             ovf_set = 1'b1;
         end
         exp_ovf  = ovf_set | (exp_ovf & ~s_clear);
         exp_udr  = (fstart && !pop_ok) | (exp_udr & ~s_clear);
         exp_bclk = ((cyc / BD) % 2) == 1;
         if (fall) begin
            shifted = cur_frame << (kbit % DW);
            exp_sd  = shifted[DW-1];
            exp_lr  = !((kbit == FB - 1) || (kbit <= DW - 2));
         end
      end
      if (started) begin
         #1;
         checks += 6;
         if (i2s_bclk !== exp_bclk) begin
            errors++;
            $display("FAIL sb_bclk cyc=%0d got=%b exp=%b", cyc, i2s_bclk, exp_bclk);
         end
         if (i2s_lrclk !== exp_lr) begin
            errors++;
            $display("FAIL sb_lrclk cyc=%0d got=%b exp=%b", cyc, i2s_lrclk, exp_lr);
         end
         if (i2s_sdata !== exp_sd) begin
            errors++;
            $display("FAIL sb_sdata cyc=%0d got=%b exp=%b", cyc, i2s_sdata, exp_sd);
         end
         if (fifo_level !== 3'(model_q.size())) begin
            errors++;
            $display("FAIL sb_level cyc=%0d got=%0d exp=%0d", cyc, fifo_level, model_q.size());
         end
         if (overflow !== exp_ovf) begin
            errors++;
            $display("FAIL sb_overflow cyc=%0d got=%b exp=%b", cyc, overflow, exp_ovf);
         end
         if (underrun !== exp_udr) begin
            errors++;
            $display("FAIL sb_underrun cyc=%0d got=%b exp=%b", cyc, underrun, exp_udr);
         end
         if (fall) begin
            cap_sd = {cap_sd[FB-2:0], i2s_sdata};
            cap_lr = {cap_lr[FB-2:0], i2s_lrclk};
            if (kbit == FB - 1) begin
               frame_log.push_back(cap_sd);
               lr_log.push_back(cap_lr);
            end
         end
      end
   end

   task automatic at_cyc(input int target);
      int n = 0;
      while (cyc != target && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (cyc != target) begin
         checks++;
         errors++;
         $display("FAIL wait_cyc got=%0d exp=%0d", cyc, target);
      end
   endtask

   task automatic wait_frames(input int n);
      int t = 0;
      while (frame_log.size() < n && t < 5000) begin
         @(negedge clk);
         t++;
      end
      if (frame_log.size() < n) begin
         checks++;
         errors++;
         $display("FAIL wait_frames got=%0d exp=%0d", frame_log.size(), n);
      end
   endtask

   task automatic push_at(input int edge_idx, input logic [DW-1:0] d);
      at_cyc(edge_idx - 1);
      audio_valid = 1'b1;
      audio_in    = d;
      @(negedge clk);
      audio_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      audio_valid = 1'b0;
      clear_flags = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underrun} !== 5'b0 || fifo_level !== 3'd0) begin
         errors++;
         $display("FAIL reset_values got=%b%b%b%b%b lvl=%0d exp=00000 lvl=0",
                  i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underrun, fifo_level);
      end
      rst = 1'b0;
      at_cyc(BD - 1);
      checks++;
      if (i2s_bclk !== 1'b0) begin
         errors++;
         $display("FAIL bclk_before_rise got=%b exp=0", i2s_bclk);
      end
      at_cyc(BD);
      checks++;
      if (i2s_bclk !== 1'b1) begin
         errors++;
         $display("FAIL bclk_first_rise got=%b exp=1", i2s_bclk);
      end
   endtask

   task automatic test_basic_frame();
      do_reset();
      push_at(1, 16'hA5C3);
      wait_frames(1);
      checks += 3;
      if (frame_log.size() < 1 || frame_log[0] !== 32'hA5C3_A5C3) begin
         errors++;
         $display("FAIL basic_sdata got=%h exp=a5c3a5c3", (frame_log.size() > 0) ? frame_log[0] : 32'hx);
      end
      if (lr_log.size() < 1 || lr_log[0] !== 32'h0001_FFFE) begin
         errors++;
         $display("FAIL basic_lrclk got=%h exp=0001fffe", (lr_log.size() > 0) ? lr_log[0] : 32'hx);
      end
      if (underrun !== 1'b0) begin
         errors++;
         $display("FAIL basic_no_underrun got=%b exp=0", underrun);
      end
   endtask

   task automatic test_underrun();
      do_reset();
      at_cyc(BCLK_T);
      checks++;
      if (underrun !== 1'b1) begin
         errors++;
         $display("FAIL underrun_first_frame got=%b exp=1", underrun);
      end
      at_cyc(49);
      clear_flags = 1'b1;
      @(negedge clk);
      clear_flags = 1'b0;
      checks++;
      if (underrun !== 1'b0) begin
         errors++;
         $display("FAIL underrun_clear got=%b exp=0", underrun);
      end
      at_cyc(BCLK_T + FB * BCLK_T - 1);
      checks += 2;
      if (frame_log.size() < 1 || frame_log[0] !== '0) begin
         errors++;
         $display("FAIL underrun_zero_frame got=%h exp=00000000", (frame_log.size() > 0) ? frame_log[0] : 32'hx);
      end
      if (underrun !== 1'b0) begin
         errors++;
         $display("FAIL underrun_stays_clear got=%b exp=0", underrun);
      end
      at_cyc(BCLK_T + FB * BCLK_T);
      checks++;
      if (underrun !== 1'b1) begin
         errors++;
         $display("FAIL underrun_reset got=%b exp=1", underrun);
      end
   endtask

   task automatic test_overflow();
      logic [DW-1:0] s [6];
      s = '{16'h1234, 16'h2345, 16'h3456, 16'h4567, 16'h5678, 16'h6789};
      do_reset();
      for (int i = 0; i < 6; i++) push_at(10 + i, s[i]);
      checks += 2;
      if (fifo_level !== 3'd4) begin
         errors++;
         $display("FAIL overflow_level got=%0d exp=4", fifo_level);
      end
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_flag got=%b exp=1", overflow);
      end
      wait_frames(6);
      for (int i = 0; i < 6; i++) begin
         logic [FB-1:0] exp_f;
         exp_f = (i >= 1 && i <= 4) ? {s[i-1], s[i-1]} : '0;
         checks++;
         if (frame_log.size() <= i || frame_log[i] !== exp_f) begin
            errors++;
            $display("FAIL overflow_frame%0d got=%h exp=%h", i,
                     (frame_log.size() > i) ? frame_log[i] : 32'hx, exp_f);
         end
      end
   endtask

   task automatic test_collision();
      logic [DW-1:0] s [5];
      s = '{16'h0F0F, 16'hF0F0, 16'h3C3C, 16'hC3C3, 16'h5AA5};
      do_reset();
      for (int i = 0; i < 4; i++) push_at(10 + i, s[i]);
      push_at(BCLK_T + FB * BCLK_T, s[4]);
      checks += 2;
      if (fifo_level !== 3'd4) begin
         errors++;
         $display("FAIL collision_level got=%0d exp=4", fifo_level);
      end
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL collision_no_overflow got=%b exp=0", overflow);
      end
      wait_frames(6);
      checks += 2;
      if (frame_log.size() < 2 || frame_log[1] !== {s[0], s[0]}) begin
         errors++;
         $display("FAIL collision_first got=%h exp=%h", (frame_log.size() > 1) ? frame_log[1] : 32'hx, {s[0], s[0]});
      end
      if (frame_log.size() < 6 || frame_log[5] !== {s[4], s[4]}) begin
         errors++;
         $display("FAIL collision_new got=%h exp=%h", (frame_log.size() > 5) ? frame_log[5] : 32'hx, {s[4], s[4]});
      end
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      push_at(10, 16'hAAAA);
      push_at(11, 16'h5555);
      at_cyc(BCLK_T + 7 * BCLK_T);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underrun} !== 5'b0 || fifo_level !== 3'd0) begin
         errors++;
         $display("FAIL midreset_values got=%b%b%b%b%b lvl=%0d exp=00000 lvl=0",
                  i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underrun, fifo_level);
      end
      rst = 1'b0;
      push_at(1, 16'h8001);
      at_cyc(BCLK_T - 1);
      checks++;
      if (i2s_bclk !== 1'b1 || i2s_sdata !== 1'b0) begin
         errors++;
         $display("FAIL midreset_prestart got=%b%b exp=10", i2s_bclk, i2s_sdata);
      end
      at_cyc(BCLK_T);
      checks++;
      if (i2s_bclk !== 1'b0 || i2s_sdata !== 1'b1 || i2s_lrclk !== 1'b0) begin
         errors++;
         $display("FAIL midreset_first_msb got=%b%b%b exp=010", i2s_bclk, i2s_sdata, i2s_lrclk);
      end
      wait_frames(2);
      checks += 2;
      if (frame_log.size() < 1 || frame_log[0] !== 32'h8001_8001) begin
         errors++;
         $display("FAIL midreset_frame0 got=%h exp=80018001", (frame_log.size() > 0) ? frame_log[0] : 32'hx);
      end
      if (frame_log.size() < 2 || frame_log[1] !== '0) begin
         errors++;
         $display("FAIL midreset_discard got=%h exp=00000000", (frame_log.size() > 1) ? frame_log[1] : 32'hx);
      end
   endtask

   task automatic test_sign_extremes();
      do_reset();
      push_at(1, 16'h8000);
      push_at(2, 16'h7FFF);
      wait_frames(2);
      checks += 2;
      if (frame_log.size() < 1 || frame_log[0] !== 32'h8000_8000) begin
         errors++;
         $display("FAIL sign_min got=%h exp=80008000", (frame_log.size() > 0) ? frame_log[0] : 32'hx);
      end
      if (frame_log.size() < 2 || frame_log[1] !== 32'h7FFF_7FFF) begin
         errors++;
         $display("FAIL sign_max got=%h exp=7fff7fff", (frame_log.size() > 1) ? frame_log[1] : 32'hx);
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_underrun();
      test_overflow();
      test_collision();
      test_reset_mid_frame();
      test_sign_extremes();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog time=%0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
